// File: rtl/cues_ring_sequencer.sv
// cues_ring_sequencer
//   Clocked sequencer for a self-timed ring of C-element handshake stages.
//   It holds the ring in reset, injects a programmed number of tokens through
//   the head stage 4-phase SENDIN/ACKOUT handshake, then counts tokens passing
//   a tap stage. It stops on target count, on a STOP request or on a
//   handshake timeout.
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start, stop         1-cycle requests (start: reset/inject/run, stop: freeze/abort)
//   tokens, target      run setup, sampled on an accepted start (target 0 = no auto-stop)
//   ring_resetn         ring stage RESETN (active low)
//   ring_lopen          ring stage LOPEN gates, all bits equal
//   inj_send, inj_ack   head stage SENDIN out / ACKOUT in (inj_ack is async)
//   tap_cp              tap stage CP (async)
//   busy, done, err     status: active run, 1-cycle stop pulse, sticky timeout
//   count               CP rising edges counted while running (saturating)
module cues_ring_sequencer #(
    parameter int NSTAGE  = 8,
    parameter int TOKW    = 4,
    parameter int CNTW    = 16,
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 255,
    parameter int SYNC    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [TOKW-1:0]   tokens,
    input  logic [CNTW-1:0]   target,
    output logic              ring_resetn,
    output logic [NSTAGE-1:0] ring_lopen,
    output logic              inj_send,
    input  logic              inj_ack,
    input  logic              tap_cp,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNTW-1:0]   count
);

    localparam int MAXC = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RINGRST, S_INJ_REQ, S_INJ_REL, S_RUN, S_STOPPED, S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [SYNC-1:0] ack_sync, cp_sync;
    logic            ack_s, cp_s, cp_s_d, cp_rise;
    logic [TW-1:0]   timer;
    logic [TOKW-1:0] rem;
    logic [CNTW-1:0] tgt, count_inc;
    logic            accept, count_en, timed_out, rst_done;

    assign ack_s     = ack_sync[SYNC-1];
    assign cp_s      = cp_sync[SYNC-1];
    assign cp_rise   = cp_s & ~cp_s_d;
    assign count_inc = (count == '1) ? count : count + CNTW'(1);
    assign count_en  = (state == S_RUN) && cp_rise;
    assign timed_out = (timer == TW'(TIMEOUT - 1));
    assign rst_done  = (timer == TW'(RST_CYC - 1));
    // START is only honoured from a quiescent state and never together with STOP.
    assign accept    = start && !stop &&
                       (state == S_IDLE || state == S_STOPPED || state == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ring_resetn = 1'b0;
        ring_lopen  = '0;
        inj_send    = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE, S_STOPPED, S_ERROR: begin
                ring_resetn = (state == S_STOPPED);
                if (accept) state_nxt = S_RINGRST;
            end
            S_RINGRST: begin
                busy = 1'b1;
                if (stop)          state_nxt = S_IDLE;
                else if (rst_done) state_nxt = (rem != '0) ? S_INJ_REQ : S_RUN;
            end
            S_INJ_REQ: begin
                ring_resetn = 1'b1;
                ring_lopen  = '1;
                inj_send    = 1'b1;
                busy        = 1'b1;
                if (stop)           state_nxt = S_IDLE;
                else if (ack_s)     state_nxt = S_INJ_REL;
                else if (timed_out) state_nxt = S_ERROR;
            end
            S_INJ_REL: begin
                ring_resetn = 1'b1;
                ring_lopen  = '1;
                busy        = 1'b1;
                if (stop)           state_nxt = S_IDLE;
                else if (!ack_s)    state_nxt = (rem == TOKW'(1)) ? S_RUN : S_INJ_REQ;
                else if (timed_out) state_nxt = S_ERROR;
            end
            S_RUN: begin
                ring_resetn = 1'b1;
                ring_lopen  = '1;
                busy        = 1'b1;
                // Auto-stop lands on the same edge that writes the final count.
                if (stop || (count_en && tgt != '0 && count_inc == tgt))
                    state_nxt = S_STOPPED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Per-state cycle timer, restarted on every state change.
    always_ff @(posedge clk) begin
        if (reset)                   timer <= '0;
        else if (state_nxt != state) timer <= '0;
        else if (state == S_RINGRST || state == S_INJ_REQ || state == S_INJ_REL)
                                     timer <= timer + TW'(1);
        else                         timer <= '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_sync <= '0;
            cp_sync  <= '0;
            cp_s_d   <= 1'b0;
            rem      <= '0;
            tgt      <= '0;
            count    <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC-2:0], inj_ack};
            cp_sync  <= {cp_sync[SYNC-2:0], tap_cp};
            cp_s_d   <= cp_s;
            done     <= (state_nxt == S_STOPPED) && (state != S_STOPPED);
            if (accept) begin
                rem   <= tokens;
                tgt   <= target;
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (count_en) count <= count_inc;
                if (state == S_INJ_REL && !stop && !ack_s) rem <= rem - TOKW'(1);
                if (state_nxt == S_ERROR && state != S_ERROR) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cues_ring_sequencer.sv
// tb_cues_ring_sequencer
//   Directed and randomized checks of cues_ring_sequencer. A second instance
//   with a 4-bit counter exercises saturation. Expected values come from the
//   run rules: RST_CYC reset cycles, one SEND per token, count = edges capped
//   by target (or by 2^CNTW-1), one DONE per stop.
module tb_cues_ring_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, stop, inj_ack, tap_cp;
    logic [3:0]  tokens;
    logic [15:0] target;
    logic        ring_resetn, inj_send, busy, done, err;
    logic [7:0]  ring_lopen;
    logic [15:0] count;

    logic        start2, stop2;
    logic [3:0]  target2;
    logic        rr2, snd2, busy2, done2, err2;
    logic [7:0]  lo2;
    logic [3:0]  count2;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int done2_seen = 0;

    always #5 clk = ~clk;

    cues_ring_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .tokens(tokens), .target(target),
        .ring_resetn(ring_resetn), .ring_lopen(ring_lopen), .inj_send(inj_send),
        .inj_ack(inj_ack), .tap_cp(tap_cp),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    cues_ring_sequencer #(.CNTW(4)) u_sat (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2),
        .tokens(4'd0), .target(target2),
        .ring_resetn(rr2), .ring_lopen(lo2), .inj_send(snd2),
        .inj_ack(inj_ack), .tap_cp(tap_cp),
        .busy(busy2), .done(done2), .err(err2), .count(count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read there too.
    task automatic tick;
        @(negedge clk);
        if (done === 1'b1)  done_seen++;
        if (done2 === 1'b1) done2_seen++;
    endtask

    task automatic launch(input int tk, input int tg);
        int lowcnt;
        tokens = 4'(tk);
        target = 16'(tg);
        start = 1'b1; tick; start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        lowcnt = 0;
        while (busy === 1'b1 && ring_resetn === 1'b0 && lowcnt < 50) begin
            lowcnt++;
            tick;
        end
        chk("rst_low_cycles", lowcnt, 4);
    endtask

    task automatic wait_send(input logic lvl, input string tag);
        int n;
        n = 0;
        while (inj_send !== lvl && n < 300) begin
            tick;
            n++;
        end
        chk(tag, 32'(inj_send), 32'(lvl));
    endtask

    // Ring head model: acknowledges each SEND level after dly cycles.
    task automatic serve(input int ntok, input int dly);
        int extra;
        for (int i = 0; i < ntok; i++) begin
            wait_send(1'b1, "send_rise");
            chk("lopen_open", 32'(ring_lopen), 32'hFF);
            repeat (dly) tick;
            inj_ack = 1'b1;
            wait_send(1'b0, "send_fall");
            repeat (dly) tick;
            inj_ack = 1'b0;
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (inj_send === 1'b1) extra++;
        end
        chk("no_extra_send", extra, 0);
    endtask

    task automatic cp_edges(input int n);
        for (int i = 0; i < n; i++) begin
            tap_cp = 1'b1; tick; tick;
            tap_cp = 1'b0; tick; tick;
        end
    endtask

    initial begin
        int tk, tg, dly, nrun, n, exp_cnt;
        reset = 1'b1; start = 1'b0; stop = 1'b0; inj_ack = 1'b0; tap_cp = 1'b0;
        tokens = '0; target = '0; start2 = 1'b0; stop2 = 1'b0; target2 = '0;
        repeat (3) tick;
        chk("rst_resetn", 32'(ring_resetn), 0);
        chk("rst_lopen", 32'(ring_lopen), 0);
        chk("rst_send", 32'(inj_send), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_count", 32'(count), 0);
        reset = 1'b0;
        tick;

        // 3 tokens, ack delay 3, auto-stop at 10
        done_seen = 0;
        launch(3, 10);
        serve(3, 3);
        tap_cp = 1'b1;
        tick; chk("cp_lat1", 32'(count), 0);
        tick; chk("cp_lat2", 32'(count), 0);
        tick; chk("cp_lat3", 32'(count), 1);
        tap_cp = 1'b0; tick; tick;
        cp_edges(9);
        chk("t1_count", 32'(count), 10);
        chk("t1_done", done_seen, 1);
        chk("t1_lopen", 32'(ring_lopen), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_resetn", 32'(ring_resetn), 1);

        // no tokens, no target, manual stop
        done_seen = 0;
        launch(0, 0);
        chk("t2_run_resetn", 32'(ring_resetn), 1);
        chk("t2_run_send", 32'(inj_send), 0);
        cp_edges(20);
        chk("t2_count_run", 32'(count), 20);
        chk("t2_no_autostop", done_seen, 0);
        stop = 1'b1; tick; stop = 1'b0;
        chk("t2_stop_busy", 32'(busy), 0);
        tick; tick;
        chk("t2_count", 32'(count), 20);
        chk("t2_done", done_seen, 1);
        start = 1'b1; tick; start = 1'b0;
        chk("t2_restart_clr", 32'(count), 0);
        stop = 1'b1; tick; stop = 1'b0;
        chk("t2_abort_busy", 32'(busy), 0);
        chk("t2_abort_nodone", done_seen, 1);

        // ACK never arrives: timeout
        done_seen = 0;
        launch(2, 0);
        wait_send(1'b1, "t3_send");
        n = 0;
        while (inj_send === 1'b1 && n < 400) begin
            n++;
            tick;
        end
        chk("t3_timeout_cyc", n, 255);
        chk("t3_err", 32'(err), 1);
        chk("t3_resetn", 32'(ring_resetn), 0);
        chk("t3_busy", 32'(busy), 0);
        tick; tick;
        chk("t3_err_sticky", 32'(err), 1);
        tokens = '0;
        start = 1'b1; tick; start = 1'b0;
        chk("t3_err_clr", 32'(err), 0);
        chk("t3_restart", 32'(busy), 1);
        stop = 1'b1; tick; stop = 1'b0;
        chk("t3_nodone", done_seen, 0);

        // STOP during INJ_REL aborts; START+STOP ignored
        done_seen = 0;
        launch(2, 0);
        wait_send(1'b1, "t4_send");
        inj_ack = 1'b1;
        wait_send(1'b0, "t4_rel");
        stop = 1'b1; tick; stop = 1'b0;
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_resetn", 32'(ring_resetn), 0);
        chk("t4_abort_lopen", 32'(ring_lopen), 0);
        inj_ack = 1'b0;
        tick; tick;
        chk("t4_nodone", done_seen, 0);
        start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
        chk("t4_both_busy", 32'(busy), 0);
        tick; tick;
        chk("t4_both_idle", 32'(busy), 0);

        // 4-bit counter saturation
        done2_seen = 0;
        start2 = 1'b1; tick; start2 = 1'b0;
        repeat (6) tick;
        cp_edges(20);
        chk("t5_sat", 32'(count2), 15);
        chk("t5_busy", 32'(busy2), 1);
        chk("t5_main_idle", 32'(busy), 0);
        stop2 = 1'b1; tick; stop2 = 1'b0;
        chk("t5_done", done2_seen, 1);
        chk("t5_stop_lopen", 32'(lo2), 0);
        chk("t5_stop_resetn", 32'(rr2), 1);
        chk("t5_err", 32'(err2), 0);
        chk("t5_send", 32'(snd2), 0);
        cp_edges(3);
        chk("t5_frozen", 32'(count2), 15);

        // reset in RUN
        launch(0, 0);
        cp_edges(7);
        chk("t6_count", 32'(count), 7);
        reset = 1'b1; tick;
        chk("t6_resetn", 32'(ring_resetn), 0);
        chk("t6_lopen", 32'(ring_lopen), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_count0", 32'(count), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_err", 32'(err), 0);
        reset = 1'b0; tick; tick;
        chk("t6_idle", 32'(busy), 0);

        // randomized runs
        for (int it = 0; it < 6; it++) begin
            tk   = $urandom_range(0, 4);
            tg   = $urandom_range(0, 9);
            dly  = $urandom_range(0, 4);
            nrun = (tg != 0) ? tg + 2 : $urandom_range(1, 8);
            exp_cnt = (tg != 0 && tg < nrun) ? tg : nrun;
            done_seen = 0;
            launch(tk, tg);
            serve(tk, dly);
            cp_edges(nrun);
            if (tg == 0) begin
                stop = 1'b1; tick; stop = 1'b0;
            end
            tick; tick;
            chk("rnd_count", 32'(count), 32'(exp_cnt));
            chk("rnd_done", done_seen, 1);
            chk("rnd_busy", 32'(busy), 0);
            chk("rnd_lopen", 32'(ring_lopen), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
